// File: rtl/hazard_stall_controller_pkg.sv
// Shared constants for the pipeline hazard/stall sequencer.
package hazard_stall_controller_pkg;

    // Architectural register index width (r0..r15).
    localparam int REG_W = 4;

    // Sequencer state encoding, visible on the state output.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle of the hazard/stall sequencer.
interface hazard_stall_controller_if
    import hazard_stall_controller_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             fwd_en_cfg;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             exe_wb_en;
    logic [REG_W-1:0] exe_dest;
    logic             exe_mem_r_en;
    logic             mem_wb_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             stat_clr;

    logic             freeze_if;
    logic             freeze_id;
    logic             bubble_exe;
    logic             freeze_back;
    logic             flush;
    logic             fwd_active;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    // Pipeline / environment side.
    modport master (
        output fwd_en_cfg, id_valid, id_src1, id_src2, id_two_src,
               exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest,
               mem_req, mem_ready, branch_taken, stat_clr,
        input  freeze_if, freeze_id, bubble_exe, freeze_back, flush,
               fwd_active, state, stall_count, mem_timeout
    );

    // Sequencer side.
    modport slave (
        input  fwd_en_cfg, id_valid, id_src1, id_src2, id_two_src,
               exe_wb_en, exe_dest, exe_mem_r_en, mem_wb_en, mem_dest,
               mem_req, mem_ready, branch_taken, stat_clr,
        output freeze_if, freeze_id, bubble_exe, freeze_back, flush,
               fwd_active, state, stall_count, mem_timeout
    );

endinterface

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Combinational RAW hazard compare for the instruction in ID.
module hazard_detect
    import hazard_stall_controller_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mem_r_en,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    output logic             hz_fwd,
    output logic             hz_nofwd
);
    logic s1_exe, s1_mem, s2_exe, s2_mem;

    // r15 is compared like any other register, no special case.
    assign s1_exe = exe_wb_en & (id_src1 == exe_dest);
    assign s1_mem = mem_wb_en & (id_src1 == mem_dest);
    assign s2_exe = id_two_src & exe_wb_en & (id_src2 == exe_dest);
    assign s2_mem = id_two_src & mem_wb_en & (id_src2 == mem_dest);

    // Without forwarding any in-flight producer blocks the reader.
    assign hz_nofwd = id_valid & (s1_exe | s1_mem | s2_exe | s2_mem);
    // With forwarding only a load still in EXE cannot be bypassed.
    assign hz_fwd   = id_valid & exe_mem_r_en & (s1_exe | s2_exe);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: freeze/bubble/flush control, forwarding-mode latch,
// memory-wait timeout and saturating stall statistics.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
)(
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               fwd_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               tmo_q;
    logic [CNT_W-1:0]   cnt_q;

    logic hz_fwd, hz_nofwd, hz, mem_stall, idle;
    logic freeze_if, freeze_id, bubble_exe, freeze_back, flush;

    hazard_detect u_hazard_detect (
        .id_valid     (bus.id_valid),
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_two_src   (bus.id_two_src),
        .exe_wb_en    (bus.exe_wb_en),
        .exe_dest     (bus.exe_dest),
        .exe_mem_r_en (bus.exe_mem_r_en),
        .mem_wb_en    (bus.mem_wb_en),
        .mem_dest     (bus.mem_dest),
        .hz_fwd       (hz_fwd),
        .hz_nofwd     (hz_nofwd)
    );

    // mem_ready releases the pipeline in the same cycle it arrives.
    assign mem_stall = bus.mem_req & ~bus.mem_ready;
    assign hz        = fwd_q ? hz_fwd : hz_nofwd;

    // Priority decode: memory wait, then taken branch, then RAW hazard.
    always_comb begin
        state_d     = ST_RUN;
        freeze_if   = 1'b0;
        freeze_id   = 1'b0;
        bubble_exe  = 1'b0;
        freeze_back = 1'b0;
        flush       = 1'b0;
        idle        = 1'b0;
        if (mem_stall) begin
            state_d     = ST_MEM_WAIT;
            freeze_if   = 1'b1;
            freeze_id   = 1'b1;
            freeze_back = 1'b1;
        end else if (bus.branch_taken) begin
            flush = 1'b1;
        end else if (hz) begin
            state_d    = ST_LD_STALL;
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            bubble_exe = 1'b1;
        end else begin
            idle = 1'b1;
        end
        // Reset forces every control output low immediately.
        if (rst) begin
            freeze_if   = 1'b0;
            freeze_id   = 1'b0;
            bubble_exe  = 1'b0;
            freeze_back = 1'b0;
            flush       = 1'b0;
            idle        = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Forwarding mode only changes on a clean RUN cycle so a stall in
    // progress keeps the hazard rule it started under.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       fwd_q <= 1'b0;
        else if (idle) fwd_q <= bus.fwd_en_cfg;
    end

    // Consecutive memory-wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (!mem_stall)
                wait_q <= '0;
            else if (wait_q != WAIT_W'(MEM_TIMEOUT))
                wait_q <= wait_q + WAIT_W'(1);
            if (bus.stat_clr)
                tmo_q <= 1'b0;
            else if (mem_stall && wait_q >= WAIT_W'(MEM_TIMEOUT - 1))
                tmo_q <= 1'b1;
        end
    end

    // Saturating count of cycles with the front end frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.stat_clr)
            cnt_q <= '0;
        else if (freeze_if && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.freeze_if   = freeze_if;
    assign bus.freeze_id   = freeze_id;
    assign bus.bubble_exe  = bubble_exe;
    assign bus.freeze_back = freeze_back;
    assign bus.flush       = flush;
    assign bus.fwd_active  = fwd_q;
    assign bus.state       = state_q;
    assign bus.stall_count = cnt_q;
    assign bus.mem_timeout = tmo_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencer for the 5-stage ARM core: detects RAW hazards in ID, memory-wait stalls in MEM and taken branches in EXE, and drives freeze/bubble/flush for the pipeline registers.
- Owns the forwarding configuration: latches the forwarding mode and drives the enable of the operand forwarding unit.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
- CNT_W, 16, width of stall_count.
- MEM_TIMEOUT, 255, MEM_WAIT cycles after which mem_timeout sets.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- fwd_en_cfg  in  1  requested forwarding mode (1 = forwarding on)
- id_valid  in  1  ID holds a real instruction
- id_src1  in  4  ID source register 1
- id_src2  in  4  ID source register 2
- id_two_src  in  1  src2 is actually read
- exe_wb_en  in  1  EXE instruction writes back
- exe_dest  in  4  EXE destination
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_wb_en  in  1  MEM instruction writes back
- mem_dest  in  4  MEM destination
- mem_req  in  1  MEM stage access in progress
- mem_ready  in  1  memory completes this cycle
- branch_taken  in  1  EXE resolved a taken branch
- stat_clr  in  1  synchronous clear of stall_count and mem_timeout
- freeze_if  out  1  hold PC and IF/ID
- freeze_id  out  1  hold ID/EXE inputs (ID instruction retained)
- bubble_exe  out  1  load NOP into ID/EXE
- freeze_back  out  1  hold ID/EXE, EXE/MEM and MEM/WB
- flush  out  1  clear IF/ID and ID/EXE
- fwd_active  out  1  enable for the forwarding unit
- state  out  2  0 = RUN, 1 = LD_STALL, 2 = MEM_WAIT
- stall_count  out  CNT_W  saturating stall-cycle count
- mem_timeout  out  1  sticky error flag

Behaviour:
- Reset: state = RUN, fwd_active = 0, stall_count = 0, mem_timeout = 0, wait counter = 0.
- All control outputs are 0 during reset.
- mem_stall = mem_req & ~mem_ready.
- hz_nofwd = id_valid & ((exe_wb_en & src1 == exe_dest) | (mem_wb_en & src1 == mem_dest) | id_two_src & ((exe_wb_en & src2 == exe_dest) | (mem_wb_en & src2 == mem_dest))).
- hz_fwd = id_valid & exe_wb_en & exe_mem_r_en & (src1 == exe_dest | id_two_src & src2 == exe_dest).
- hz = fwd_active ? hz_fwd : hz_nofwd.
- Priority, evaluated combinationally each cycle:
  1. mem_stall: freeze_if = freeze_id = freeze_back = 1; bubble_exe = flush = 0; branch_taken and hz are ignored because they are held.
  2. branch_taken: flush = 1 and nothing else, so the wrong-path hazard does not stall.
  3. hz: freeze_if = freeze_id = bubble_exe = 1.
  4. Otherwise all outputs are 0.
- When mem_ready arrives, the pipeline advances in that same cycle, so the stall costs zero added latency.
- State register (next state):
  - mem_stall gives MEM_WAIT.
  - Otherwise, hz & ~branch_taken gives LD_STALL.
  - Otherwise RUN.
- In forwarding mode a load-use stall lasts exactly 1 cycle. With forwarding off, a stall lasts up to 2 cycles (EXE, then MEM producer).
- fwd_active loads fwd_en_cfg only on a cycle where the next state is RUN and no output is asserted. A config change during a stall or flush is deferred.
- Wait counter:
  - Counts consecutive MEM_WAIT cycles and resets to 0 when leaving MEM_WAIT.
  - On reaching MEM_TIMEOUT, mem_timeout sets. It stays set until stat_clr or rst.
  - The counter saturates and does not wrap.
- stall_count increments every cycle freeze_if = 1 and saturates at 2^CNT_W − 1.
- stat_clr has priority over increment in the same cycle.
- Destination r15 is compared like any other register; there is no special case.
- Reset mid-stall returns to RUN immediately (asynchronous). Outputs drop to 0 within the same cycle.

Decomposition:
- Shared package holds the state encoding constants (ST_RUN = 2'd0, ST_LD_STALL = 2'd1, ST_MEM_WAIT = 2'd2) and the register width constant (4).
- One sub-module, hazard_detect: the purely combinational hz_fwd / hz_nofwd compare logic. It is reused by the verification scoreboard.
- The FSM, config latch and counters stay in the top module.

Test Plan:
- Load-use, forwarding on: load writes r3 in EXE, ID reads r3 as src1. Required: freeze_if = bubble_exe = 1 for exactly 1 cycle, state = 1, then RUN; stall_count = 1.
- Forwarding off: ALU op writes r5, next instruction reads r5 as src2 with id_two_src = 1. Required: stall for 2 cycles; stall_count = 2.
- Branch with hazard: branch_taken = 1 while hz = 1. Required: flush = 1, bubble_exe = 0, state stays RUN.
- Memory wait: mem_req = 1 with mem_ready low for 4 cycles, and branch_taken = 1 during that window. Required: freeze_back = 1 for 4 cycles, no flush until the memory completes.
- Timeout: MEM_TIMEOUT = 3 and mem_ready held low for 5 cycles. Required: mem_timeout = 1 after the 3rd wait cycle; stat_clr clears it; stall_count saturates at 2^CNT_W − 1 when CNT_W = 2.
- Config deferral: toggle fwd_en_cfg during LD_STALL. Required: fwd_active changes only on the first clean RUN cycle. Asserting rst mid-MEM_WAIT gives state = 0 with all outputs 0 immediately.
